// File: rtl/dvfs_actuator.sv
// DVFS actuator: sequences regulator and PLL changes so that voltage always
// leads a frequency increase and trails a frequency decrease.
module dvfs_actuator #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  voltage_level_i,
  input  logic [3:0]  frequency_level_i,
  input  logic        dvfs_update_i,
  output logic [2:0]  vreg_level_o,
  output logic        vreg_req_o,
  input  logic        vreg_ack_i,
  output logic [3:0]  pll_freq_o,
  output logic        pll_req_o,
  input  logic        pll_lock_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  input  logic        clear_err_i,
  output logic [15:0] transition_count_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, V_RAISE, V_SETTLE_UP, F_SET, F_SETTLE, V_LOWER, V_SETTLE_DN
  } state_t;

  state_t        state_reg, state_next;
  logic          upd_prev_reg;
  logic          pend_valid_reg, pend_valid_next;
  logic [2:0]    pend_v_reg, pend_v_next;
  logic [3:0]    pend_f_reg, pend_f_next;
  logic [2:0]    tv_reg, tv_next;
  logic [3:0]    tf_reg, tf_next;
  logic [2:0]    vlevel_reg, vlevel_next;
  logic          vreq_reg, vreq_next;
  logic [3:0]    pfreq_reg, pfreq_next;
  logic          preq_reg, preq_next;
  logic          done_reg, done_next;
  logic          error_reg, error_next;
  logic [15:0]   count_reg, count_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic [TW-1:0] timeout_reg, timeout_next;

  logic req_edge;
  logic timeout_fire;
  logic finish;

  assign req_edge = dvfs_update_i & ~upd_prev_reg;

  always_comb begin
    state_next      = state_reg;
    pend_valid_next = pend_valid_reg;
    pend_v_next     = pend_v_reg;
    pend_f_next     = pend_f_reg;
    tv_next         = tv_reg;
    tf_next         = tf_reg;
    vlevel_next     = vlevel_reg;
    vreq_next       = vreq_reg;
    pfreq_next      = pfreq_reg;
    preq_next       = preq_reg;
    done_next       = 1'b0;
    error_next      = error_reg;
    count_next      = count_reg;
    settle_next     = settle_reg;
    timeout_next    = timeout_reg;
    timeout_fire    = 1'b0;
    finish          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pend_valid_reg) begin
          pend_valid_next = 1'b0;
          tv_next         = pend_v_reg;
          tf_next         = pend_f_reg;
          if (pend_v_reg > vlevel_reg) begin
            state_next   = V_RAISE;
            vlevel_next  = pend_v_reg;
            vreq_next    = 1'b1;
            timeout_next = '0;
          end else if (pend_f_reg != pfreq_reg) begin
            state_next   = F_SET;
            pfreq_next   = pend_f_reg;
            preq_next    = 1'b1;
            timeout_next = '0;
          end else if (pend_v_reg < vlevel_reg) begin
            state_next   = V_LOWER;
            vlevel_next  = pend_v_reg;
            vreq_next    = 1'b1;
            timeout_next = '0;
          end else begin
            // Target already in place: acknowledge without counting.
            done_next = 1'b1;
          end
        end
      end

      V_RAISE, V_LOWER: begin
        if (vreg_ack_i) begin
          vreq_next   = 1'b0;
          settle_next = '0;
          state_next  = (state_reg == V_RAISE) ? V_SETTLE_UP : V_SETTLE_DN;
        end else if (timeout_reg == TIMEOUT_LAST) begin
          vreq_next    = 1'b0;
          timeout_fire = 1'b1;
          state_next   = IDLE;
        end else begin
          timeout_next = timeout_reg + 1'b1;
        end
      end

      F_SET: begin
        if (pll_lock_i) begin
          preq_next   = 1'b0;
          settle_next = '0;
          state_next  = F_SETTLE;
        end else if (timeout_reg == TIMEOUT_LAST) begin
          preq_next    = 1'b0;
          timeout_fire = 1'b1;
          state_next   = IDLE;
        end else begin
          timeout_next = timeout_reg + 1'b1;
        end
      end

      V_SETTLE_UP: begin
        if (settle_reg == SETTLE_LAST) begin
          if (tf_reg != pfreq_reg) begin
            state_next   = F_SET;
            pfreq_next   = tf_reg;
            preq_next    = 1'b1;
            timeout_next = '0;
          end else begin
            finish = 1'b1;
          end
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end

      F_SETTLE: begin
        if (settle_reg == SETTLE_LAST) begin
          if (tv_reg < vlevel_reg) begin
            state_next   = V_LOWER;
            vlevel_next  = tv_reg;
            vreq_next    = 1'b1;
            timeout_next = '0;
          end else begin
            finish = 1'b1;
          end
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end

      V_SETTLE_DN: begin
        if (settle_reg == SETTLE_LAST) begin
          finish = 1'b1;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase

    if (finish) begin
      state_next = IDLE;
      done_next  = 1'b1;
      count_next = count_reg + 16'd1;
    end

    // A timeout in the same cycle as a clear must leave the flag set.
    if (timeout_fire) begin
      error_next = 1'b1;
    end else if (clear_err_i) begin
      error_next = 1'b0;
    end

    // Capture after the pop so a request arriving in the pop cycle survives.
    if (req_edge) begin
      pend_valid_next = 1'b1;
      pend_v_next     = voltage_level_i;
      pend_f_next     = frequency_level_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      upd_prev_reg   <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_v_reg     <= '0;
      pend_f_reg     <= '0;
      tv_reg         <= 3'b100;
      tf_reg         <= 4'h8;
      vlevel_reg     <= 3'b100;
      vreq_reg       <= 1'b0;
      pfreq_reg      <= 4'h8;
      preq_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      count_reg      <= '0;
      settle_reg     <= '0;
      timeout_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      upd_prev_reg   <= dvfs_update_i;
      pend_valid_reg <= pend_valid_next;
      pend_v_reg     <= pend_v_next;
      pend_f_reg     <= pend_f_next;
      tv_reg         <= tv_next;
      tf_reg         <= tf_next;
      vlevel_reg     <= vlevel_next;
      vreq_reg       <= vreq_next;
      pfreq_reg      <= pfreq_next;
      preq_reg       <= preq_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
      count_reg      <= count_next;
      settle_reg     <= settle_next;
      timeout_reg    <= timeout_next;
    end
  end

  assign vreg_level_o       = vlevel_reg;
  assign vreg_req_o         = vreq_reg;
  assign pll_freq_o         = pfreq_reg;
  assign pll_req_o          = preq_reg;
  assign busy_o             = (state_reg != IDLE);
  assign done_o             = done_reg;
  assign error_o            = error_reg;
  assign transition_count_o = count_reg;

endmodule

// File: tb/tb_dvfs_actuator.sv
// Scoreboard bench for dvfs_actuator: stimulus queues expected handshake
// events, a monitor pops and compares them as the DUT raises its outputs.
module tb_dvfs_actuator;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [2:0]  voltage_level_i;
  logic [3:0]  frequency_level_i;
  logic        dvfs_update_i;
  logic [2:0]  vreg_level_o;
  logic        vreg_req_o;
  logic        vreg_ack_i;
  logic [3:0]  pll_freq_o;
  logic        pll_req_o;
  logic        pll_lock_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        clear_err_i;
  logic [15:0] transition_count_o;

  always #5 clk = ~clk;

  dvfs_actuator #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(1024)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .voltage_level_i(voltage_level_i), .frequency_level_i(frequency_level_i),
    .dvfs_update_i(dvfs_update_i),
    .vreg_level_o(vreg_level_o), .vreg_req_o(vreg_req_o), .vreg_ack_i(vreg_ack_i),
    .pll_freq_o(pll_freq_o), .pll_req_o(pll_req_o), .pll_lock_i(pll_lock_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .clear_err_i(clear_err_i),
    .transition_count_o(transition_count_o)
  );

  // Event kinds: 0 vreg request rise, 1 pll request rise, 2 done pulse, 3 error rise
  typedef struct {
    int kind;
    int data;
    bit chk_aux;
    int aux;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  vack_en = 1, pack_en = 1, ack_dly = 3;
  int  vcnt = 0, pcnt = 0;
  int  cyc = 0, last_vrise = 0, last_vfall = 0, last_pfall = 0;
  logic vreq_q = 1'b0, preq_q = 1'b0, err_q = 1'b0;

  function automatic string kname(int k);
    case (k)
      0: return "vreg_req";
      1: return "pll_req";
      2: return "done";
      default: return "error";
    endcase
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic compare_ev(int kind, int data, int aux);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_%s: got data=%0d aux=%0d, required no event", kname(kind), data, aux);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.data == data && (!e.chk_aux || e.aux == aux)) begin
        passes++;
        $display("event %s data=%0d aux=%0d ok", kname(kind), data, aux);
      end else begin
        $display("FAIL event_%s: got %s data=%0d aux=%0d, required %s data=%0d aux=%0d",
                 kname(e.kind), kname(kind), data, aux, kname(e.kind), e.data,
                 e.chk_aux ? e.aux : aux);
      end
    end
  endtask

  // Regulator and PLL models: acknowledge ack_dly cycles after the request rises.
  always @(negedge clk) begin
    if (vreg_req_o && vack_en != 0) begin
      vcnt++;
      vreg_ack_i = (vcnt == ack_dly);
    end else begin
      vcnt = 0;
      vreg_ack_i = 1'b0;
    end
    if (pll_req_o && pack_en != 0) begin
      pcnt++;
      pll_lock_i = (pcnt == ack_dly);
    end else begin
      pcnt = 0;
      pll_lock_i = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    cyc++;
    if (vreg_req_o && !vreq_q) begin
      compare_ev(0, int'(vreg_level_o), cyc - last_pfall);
      last_vrise = cyc;
    end
    if (!vreg_req_o && vreq_q) last_vfall = cyc;
    if (pll_req_o && !preq_q) compare_ev(1, int'(pll_freq_o), cyc - last_vfall);
    if (!pll_req_o && preq_q) last_pfall = cyc;
    if (done_o) compare_ev(2, int'(transition_count_o), 0);
    if (error_o && !err_q) compare_ev(3, int'({busy_o, vreg_req_o}), cyc - last_vrise);
    vreq_q = vreg_req_o;
    preq_q = pll_req_o;
    err_q  = error_o;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(int kind, int data, bit chk_aux, int aux);
    ev_t e;
    e.kind = kind; e.data = data; e.chk_aux = chk_aux; e.aux = aux;
    exp_q.push_back(e);
  endtask

  task automatic request(logic [2:0] v, logic [3:0] f);
    @(negedge clk);
    voltage_level_i = v; frequency_level_i = f; dvfs_update_i = 1'b1;
    @(negedge clk);
    dvfs_update_i = 1'b0;
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL %s_drain: got %0d events outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_reset(string tag);
    check({tag, "_vreg_level"}, int'(vreg_level_o), 4);
    check({tag, "_pll_freq"},   int'(pll_freq_o), 8);
    check({tag, "_vreg_req"},   int'(vreg_req_o), 0);
    check({tag, "_pll_req"},    int'(pll_req_o), 0);
    check({tag, "_busy"},       int'(busy_o), 0);
    check({tag, "_done"},       int'(done_o), 0);
    check({tag, "_error"},      int'(error_o), 0);
    check({tag, "_count"},      int'(transition_count_o), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; voltage_level_i = '0; frequency_level_i = '0;
    dvfs_update_i = 1'b0; vreg_ack_i = 1'b0; pll_lock_i = 1'b0; clear_err_i = 1'b0;
    tick(3);
    rst_i = 1'b0;
    tick(1);
    check_reset("reset");

    // Scale-up: voltage first, PLL only after 16 settle cycles
    expect_ev(0, 7, 1'b0, 0);
    expect_ev(1, 15, 1'b1, 16);
    expect_ev(2, 1, 1'b0, 0);
    request(3'd7, 4'hF);
    drain("scale_up", 200);
    check("up_vreg_level", int'(vreg_level_o), 7);
    check("up_pll_freq", int'(pll_freq_o), 15);
    check("up_busy", int'(busy_o), 0);

    // Scale-down: PLL first, voltage lowered 16 cycles after lock
    do_reset();
    expect_ev(1, 2, 1'b0, 0);
    expect_ev(0, 1, 1'b1, 16);
    expect_ev(2, 1, 1'b0, 0);
    request(3'd1, 4'h2);
    drain("scale_down", 200);

    // Frequency only, then identical request as a no-op
    do_reset();
    expect_ev(1, 12, 1'b0, 0);
    expect_ev(2, 1, 1'b0, 0);
    request(3'd4, 4'hC);
    drain("freq_only", 200);
    tick(2);
    expect_ev(2, 1, 1'b0, 0);
    request(3'd4, 4'hC);
    drain("noop", 20);
    tick(5);
    check("noop_count", int'(transition_count_o), 1);

    // Timeout on a regulator that never acknowledges
    vack_en = 0;
    expect_ev(0, 6, 1'b0, 0);
    expect_ev(3, 0, 1'b1, 1024);
    request(3'd6, 4'hC);
    drain("timeout", 1200);
    tick(2);
    check("to_error", int'(error_o), 1);
    check("to_busy", int'(busy_o), 0);
    check("to_vreg_level", int'(vreg_level_o), 6);
    check("to_count", int'(transition_count_o), 1);
    @(negedge clk) clear_err_i = 1'b1;
    @(negedge clk) clear_err_i = 1'b0;
    check("clear_error", int'(error_o), 0);
    vack_en = 1;

    // Back-to-back: middle request is overwritten by the last one
    expect_ev(0, 7, 1'b0, 0);
    expect_ev(1, 3, 1'b1, 16);
    expect_ev(2, 2, 1'b0, 0);
    expect_ev(1, 4, 1'b0, 0);
    expect_ev(0, 6, 1'b1, 16);
    expect_ev(2, 3, 1'b0, 0);
    request(3'd7, 4'h3);
    tick(4);
    request(3'd2, 4'h1);
    tick(1);
    request(3'd6, 4'h4);
    drain("back_to_back", 300);
    tick(3);
    check("b2b_vreg_level", int'(vreg_level_o), 6);
    check("b2b_pll_freq", int'(pll_freq_o), 4);

    // Reset in the middle of F_SET, with update held high across reset
    pack_en = 0;
    expect_ev(1, 9, 1'b0, 0);
    request(3'd6, 4'h9);
    drain("fset", 50);
    tick(2);
    @(negedge clk);
    rst_i = 1'b1; dvfs_update_i = 1'b1; voltage_level_i = 3'd7; frequency_level_i = 4'hF;
    pack_en = 1;
    expect_ev(0, 7, 1'b0, 0);
    expect_ev(1, 15, 1'b1, 16);
    expect_ev(2, 1, 1'b0, 0);
    @(negedge clk);
    check_reset("mid_reset");
    rst_i = 1'b0;
    drain("post_reset", 200);
    dvfs_update_i = 1'b0;
    tick(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dvfs_actuator.md
DVFS_ACTUATOR -- requirements
Module: dvfs_actuator

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16, is the wait in cycles after each regulator or PLL acknowledge.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, is the maximum wait in cycles for an acknowledge or lock before an error is flagged.
REQ-003 clk_i  input  1  sole clock; all logic is on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 voltage_level_i  input  3  requested voltage level from the DVFS controller.
REQ-006 frequency_level_i  input  4  requested frequency level from the DVFS controller.
REQ-007 dvfs_update_i  input  1  update flag from the DVFS controller; only its rising edge is a request.
REQ-008 vreg_level_o  output  3  voltage level driven to the regulator.
REQ-009 vreg_req_o  output  1  regulator change request.
REQ-010 vreg_ack_i  input  1  regulator acknowledge.
REQ-011 pll_freq_o  output  4  frequency level driven to the PLL.
REQ-012 pll_req_o  output  1  PLL change request.
REQ-013 pll_lock_i  input  1  PLL lock acknowledge.
REQ-014 busy_o  output  1  high while a transition is in progress.
REQ-015 done_o  output  1  one-cycle pulse when a transition completes.
REQ-016 error_o  output  1  sticky timeout flag.
REQ-017 clear_err_i  input  1  clears error_o.
REQ-018 transition_count_o  output  16  count of completed transitions; wraps at 16'hFFFF to 0.

Function
REQ-019 States SHALL be IDLE, V_RAISE, V_SETTLE_UP, F_SET, F_SETTLE, V_LOWER, V_SETTLE_DN.
- A request is the rising edge of dvfs_update_i (high now, low in the previous cycle).
- The request captures voltage_level_i and frequency_level_i into a one-deep pending slot.
- A newer request overwrites the pending slot.
REQ-020 In IDLE with the pending slot valid, the block SHALL pop the slot into target registers (tv, tf) and choose the next state:
- tv > vreg_level_o: go to V_RAISE.
- tv <= vreg_level_o and tf != pll_freq_o: go to F_SET.
- tv < vreg_level_o and tf == pll_freq_o: go to V_LOWER.
- tv == vreg_level_o and tf == pll_freq_o: no-op; pulse done_o next cycle, do not increment transition_count_o.
REQ-021 Ordering SHALL be: voltage raised before the frequency change; frequency changed before the voltage is lowered.
REQ-022 On entry to V_RAISE or V_LOWER, vreg_level_o <= tv and vreg_req_o is set.
- The request is held, with vreg_level_o stable, until vreg_ack_i is sampled high.
- vreg_req_o is low the cycle after the acknowledge.
REQ-023 On entry to F_SET, pll_freq_o <= tf and pll_req_o is set, held until pll_lock_i is sampled high, then dropped the next cycle.
REQ-024 vreg_ack_i and pll_lock_i SHALL be ignored while the matching request is low.
REQ-025 Each settle state SHALL wait exactly SETTLE_CYCLES cycles after the acknowledge, then move on:
- V_SETTLE_UP goes to F_SET if tf != pll_freq_o; otherwise the transition completes.
- F_SETTLE goes to V_LOWER if tv < vreg_level_o; otherwise the transition completes.
- V_SETTLE_DN: the transition completes.
REQ-026 On completion: return to IDLE, pulse done_o for one cycle, increment transition_count_o.
REQ-027 busy_o SHALL be high in every state except IDLE.
REQ-028 A timeout counter restarts on each request assertion.
- Reaching TIMEOUT_CYCLES without an acknowledge drops the request and sets error_o.
- The state returns to IDLE with no done_o pulse and no count increment.
- The output level already updated for the failed step SHALL stay as written.
REQ-029 error_o SHALL clear only on clear_err_i.
- A simultaneous timeout and clear_err_i leaves error_o set.
- error_o does not block new requests.
REQ-030 A request arriving while busy SHALL be held in the pending slot and served from IDLE after the current transition.

Reset
REQ-031 While rst_i is high, the reset state SHALL be applied at each clock edge, including mid-transition:
- state IDLE, vreg_level_o 3'b100, pll_freq_o 4'h8.
- vreg_req_o, pll_req_o, busy_o, done_o, error_o all 0.
- transition_count_o 0; pending slot invalid.
- Previous-cycle dvfs_update_i value reset to 0, so a high dvfs_update_i right after reset counts as a request.

Verification
REQ-032 Scale-up: from reset, request V=3'b111 F=4'hF, ack after 3 cycles each.
- Expect vreg_req_o first, then pll_req_o only after 16 settle cycles.
- Expect done_o pulse and transition_count_o=1.
REQ-033 Scale-down: from V=3'b100 F=4'h8, request V=3'b001 F=4'h2.
- Expect pll_req_o with pll_freq_o=4'h2 before vreg_req_o with vreg_level_o=3'b001.
REQ-034 Frequency only: from V=3'b100 F=4'h8, request V=3'b100 F=4'hC.
- Expect only pll_req_o, done_o, count+1.
- Then repeat the identical request: expect done_o only, count unchanged.
REQ-035 Timeout: hold vreg_ack_i low with TIMEOUT_CYCLES=1024.
- Expect vreg_req_o to drop after 1024 cycles, error_o=1, busy_o=0, no done_o.
- Then clear_err_i: expect error_o=0.
REQ-036 Back-to-back and reset: issue two requests during one transition.
- Expect only the second to be served afterwards.
- Assert rst_i mid-F_SET: the next cycle shows the reset values of REQ-031.
